// File: rtl/branch_condition_unit_pkg.sv
// Shared encodings for the branch condition unit: condition codes,
// branch types and redirect FSM states.
package branch_condition_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] BR_BCOND = 2'b00;
  localparam logic [1:0] BR_CBZ   = 2'b01;
  localparam logic [1:0] BR_CBNZ  = 2'b10;
  localparam logic [1:0] BR_B     = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } bcu_state_e;

endpackage

// File: rtl/branch_condition_unit_cond_evaluator.sv
// Combinational LEGv8 condition-code evaluator; shared with future CSEL logic.
module cond_evaluator
  import branch_condition_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       taken
);

  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_HS: taken = c;
      COND_LO: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c & !z;
      COND_LS: taken = !(c & !z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z & (n == v);
      COND_LE: taken = !(!z & (n == v));
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_condition_unit.sv
// Branch resolution: flag select, target generation, one-entry redirect
// register with valid/ready handshake, and saturating taken/not-taken counters.
module branch_condition_unit
  import branch_condition_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_valid,
  output logic                  br_ready,
  input  logic [1:0]            br_type,
  input  logic [3:0]            br_cond,
  input  logic [DATA_WIDTH-1:0] br_operand,
  input  logic [DATA_WIDTH-1:0] br_pc,
  input  logic [DATA_WIDTH-1:0] br_offset,
  input  logic                  negative_in,
  input  logic                  zero_in,
  input  logic                  carry_in,
  input  logic                  overflow_in,
  input  logic                  fwd_valid,
  input  logic                  fwd_n,
  input  logic                  fwd_z,
  input  logic                  fwd_c,
  input  logic                  fwd_v,
  input  logic                  flags_pending,
  input  logic                  flush,
  output logic                  redirect_valid,
  input  logic                  redirect_ready,
  output logic                  redirect_taken,
  output logic [DATA_WIDTH-1:0] redirect_target,
  output logic [CNT_WIDTH-1:0]  taken_count,
  output logic [CNT_WIDTH-1:0]  not_taken_count
);

  bcu_state_e            state, state_next;
  logic                  flag_n, flag_z, flag_c, flag_v;
  logic                  cond_taken;
  logic                  taken;
  logic                  accept;
  logic [DATA_WIDTH-1:0] target;

  // Forwarded flags from a same-cycle setter override the status register.
  assign flag_n = fwd_valid ? fwd_n : negative_in;
  assign flag_z = fwd_valid ? fwd_z : zero_in;
  assign flag_c = fwd_valid ? fwd_c : carry_in;
  assign flag_v = fwd_valid ? fwd_v : overflow_in;

  cond_evaluator u_cond_evaluator (
    .cond  (br_cond),
    .n     (flag_n),
    .z     (flag_z),
    .c     (flag_c),
    .v     (flag_v),
    .taken (cond_taken)
  );

  always_comb begin
    taken = 1'b1;
    case (br_type)
      BR_BCOND: taken = cond_taken;
      BR_CBZ:   taken = (br_operand == '0);
      BR_CBNZ:  taken = (br_operand != '0);
      default:  taken = 1'b1;
    endcase
  end

  assign target = taken ? (br_pc + (br_offset << 2)) : (br_pc + DATA_WIDTH'(4));

  assign br_ready = reset & !flush & !flags_pending &
                    ((state == ST_IDLE) | redirect_ready);
  assign accept   = br_valid & br_ready;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_VALID;
      end
      ST_VALID: begin
        if (flush)               state_next = ST_IDLE;
        else if (accept)         state_next = ST_VALID;
        else if (redirect_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  assign redirect_valid = (state == ST_VALID);

  always_ff @(posedge clk) begin
    if (!reset) begin
      redirect_taken  <= 1'b0;
      redirect_target <= '0;
      taken_count     <= '0;
      not_taken_count <= '0;
    end else if (accept) begin
      redirect_taken  <= taken;
      redirect_target <= target;
      if (taken && taken_count != '1)          taken_count     <= taken_count + 1'b1;
      if (!taken && not_taken_count != '1)     not_taken_count <= not_taken_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_condition_unit.sv
// Randomized and directed checks of branch_condition_unit against a
// behavioural model of the handshake, condition table and counters.
module tb_branch_condition_unit;

  localparam int DW    = 64;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          br_valid;
  logic          br_ready;
  logic [1:0]    br_type;
  logic [3:0]    br_cond;
  logic [DW-1:0] br_operand, br_pc, br_offset;
  logic          negative_in, zero_in, carry_in, overflow_in;
  logic          fwd_valid, fwd_n, fwd_z, fwd_c, fwd_v;
  logic          flags_pending, flush;
  logic          redirect_valid, redirect_ready, redirect_taken;
  logic [DW-1:0] redirect_target;
  logic [CW-1:0] taken_count, not_taken_count;

  int errors = 0;
  int checks = 0;

  bit            m_valid;
  bit            m_taken;
  logic [DW-1:0] m_target;
  int            m_tc, m_ntc;

  branch_condition_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
    .br_type(br_type), .br_cond(br_cond), .br_operand(br_operand),
    .br_pc(br_pc), .br_offset(br_offset),
    .negative_in(negative_in), .zero_in(zero_in), .carry_in(carry_in),
    .overflow_in(overflow_in), .fwd_valid(fwd_valid), .fwd_n(fwd_n),
    .fwd_z(fwd_z), .fwd_c(fwd_c), .fwd_v(fwd_v),
    .flags_pending(flags_pending), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_taken(redirect_taken), .redirect_target(redirect_target),
    .taken_count(taken_count), .not_taken_count(not_taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] actual,
                       input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Condition pairs: even code tests the base predicate, odd code its inverse.
  function automatic bit ref_cond(input logic [3:0] cond, input bit n, input bit z,
                                  input bit c, input bit v);
    bit base;
    logic [2:0] grp;
    grp = cond[3:1];
    case (grp)
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  function automatic bit ref_taken();
    bit n, z, c, v;
    n = fwd_valid ? fwd_n : negative_in;
    z = fwd_valid ? fwd_z : zero_in;
    c = fwd_valid ? fwd_c : carry_in;
    v = fwd_valid ? fwd_v : overflow_in;
    case (br_type)
      2'b00:   return ref_cond(br_cond, n, z, c, v);
      2'b01:   return br_operand == 0;
      2'b10:   return br_operand != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit ref_ready();
    return reset && !flush && !flags_pending && (!m_valid || redirect_ready);
  endfunction

  // Inputs are already driven; check ready, clock once, update model, check outputs.
  task automatic step();
    bit rdy, t;
    #1;
    rdy = ref_ready();
    check("br_ready", br_ready, rdy);
    @(posedge clk);
    if (!reset) begin
      m_valid = 0; m_taken = 0; m_target = '0; m_tc = 0; m_ntc = 0;
    end else if (br_valid && rdy) begin
      t = ref_taken();
      m_valid  = 1;
      m_taken  = t;
      m_target = t ? br_pc + br_offset * 4 : br_pc + 64'd4;
      if (t) m_tc  = (m_tc  < CMAX) ? m_tc + 1  : CMAX;
      else   m_ntc = (m_ntc < CMAX) ? m_ntc + 1 : CMAX;
    end else if (flush || (m_valid && redirect_ready)) begin
      m_valid = 0;
    end
    @(negedge clk);
    check("redirect_valid", redirect_valid, m_valid);
    if (m_valid) begin
      check("redirect_taken", redirect_taken, m_taken);
      check("redirect_target", redirect_target, m_target);
    end
    check("taken_count", taken_count, m_tc);
    check("not_taken_count", not_taken_count, m_ntc);
  endtask

  task automatic idle_inputs();
    reset = 1; br_valid = 0; br_type = 2'b11; br_cond = 4'd0;
    br_operand = '0; br_pc = '0; br_offset = '0;
    negative_in = 0; zero_in = 0; carry_in = 0; overflow_in = 0;
    fwd_valid = 0; fwd_n = 0; fwd_z = 0; fwd_c = 0; fwd_v = 0;
    flags_pending = 0; flush = 0; redirect_ready = 1;
  endtask

  initial begin
    m_valid = 0; m_taken = 0; m_target = '0; m_tc = 0; m_ntc = 0;
    idle_inputs();
    reset = 0;
    @(negedge clk);
    step(); step();
    check("reset_taken", redirect_taken, 1'b0);
    check("reset_target", redirect_target, 64'd0);
    reset = 1;
    #1 check("ready_after_reset", br_ready, 1'b1);
    step();

    // B.cond EQ with Z set from the status register
    br_valid = 1; br_type = 2'b00; br_cond = 4'b0000; zero_in = 1;
    br_pc = 64'h1000; br_offset = 64'd4;
    step();
    check("eq_taken", redirect_taken, 1'b1);
    check("eq_target", redirect_target, 64'h1010);
    check("eq_tc", taken_count, 64'd1);

    // GT: forwarded flags override the architectural ones
    br_cond = 4'b1100; negative_in = 1; overflow_in = 0; zero_in = 0;
    fwd_valid = 1; fwd_n = 0; fwd_v = 0; fwd_z = 0;
    step();
    check("gt_fwd_taken", redirect_taken, 1'b1);
    fwd_valid = 0;
    step();
    check("gt_arch_taken", redirect_taken, 1'b0);
    check("gt_arch_target", redirect_target, 64'h1004);

    // CBNZ wrap and CBZ negative offset
    br_type = 2'b10; br_operand = '0; br_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check("cbnz_taken", redirect_taken, 1'b0);
    check("cbnz_wrap", redirect_target, 64'd0);
    br_type = 2'b01; br_pc = 64'h2000; br_offset = -64'sd2;
    step();
    check("cbz_taken", redirect_taken, 1'b1);
    check("cbz_target", redirect_target, 64'h1FF8);

    // Backpressure: three stalled cycles, then drain with back-to-back accept
    redirect_ready = 0; br_type = 2'b11; br_pc = 64'h3000; br_offset = 64'd16;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready", br_ready, 1'b0);
      check("stall_target", redirect_target, 64'h1FF8);
    end
    redirect_ready = 1;
    step();
    check("b2b_valid", redirect_valid, 1'b1);
    check("b2b_target", redirect_target, 64'h3040);

    // Flush while holding a redirect blocks the presented branch
    redirect_ready = 0; flush = 1;
    step();
    check("flush_valid", redirect_valid, 1'b0);
    flush = 0; redirect_ready = 1;

    // Saturation of the taken counter
    for (int i = 0; i < CMAX + 3; i++) step();
    check("tc_saturated", taken_count, 64'(CMAX));

    // Randomized traffic, including occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(63) != 0);
      flush          = ($urandom_range(7) == 0);
      flags_pending  = ($urandom_range(5) == 0);
      br_valid       = ($urandom_range(3) != 0);
      redirect_ready = $urandom_range(1);
      br_type        = 2'($urandom_range(3));
      br_cond        = 4'($urandom_range(15));
      br_operand     = ($urandom_range(2) == 0) ? '0 : {$urandom, $urandom};
      br_pc          = {$urandom, $urandom};
      br_offset      = ($urandom_range(1) == 0) ? {$urandom, $urandom}
                                                : 64'($signed(16'($urandom)));
      {negative_in, zero_in, carry_in, overflow_in} = 4'($urandom_range(15));
      fwd_valid      = $urandom_range(1);
      {fwd_n, fwd_z, fwd_c, fwd_v} = 4'($urandom_range(15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
